// File: rtl/arbitro_rr.sv
// rtl/arbitro_rr.sv - round-robin arbiter routing input FIFO words to output FIFOs by destination field
module arbitro_rr #(
   parameter int NUM_FIFOS      = 4,
   parameter int FIFO_WORD_SIZE = 10
) (
   input  logic                      clk,
   input  logic                      reset_L,
   input  logic                      arb_en,
   input  logic [NUM_FIFOS-1:0]      fifo_in_empty,
   input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data0,
   input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data1,
   input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data2,
   input  logic [FIFO_WORD_SIZE-1:0] fifo_in_data3,
   input  logic [NUM_FIFOS-1:0]      fifo_out_almost_full,
   output logic [NUM_FIFOS-1:0]      pop_in,
   output logic [NUM_FIFOS-1:0]      push_out,
   output logic [FIFO_WORD_SIZE-1:0] data_out,
   output logic                      arb_idle
);

   logic [1:0]                rr_ptr;
   logic                      s1_valid;
   logic [1:0]                s1_src;
   logic                      stall;
   logic                      grant_valid;
   logic [1:0]                grant_idx;
   logic [1:0]                scan_idx;
   logic [FIFO_WORD_SIZE-1:0] s1_word;
   logic [1:0]                s1_dest;

   // Scan from the farthest offset down so the nearest non-empty FIFO to rr_ptr wins.
   always_comb begin
      stall       = (|fifo_out_almost_full) | ~arb_en | ~reset_L;
      grant_valid = 1'b0;
      grant_idx   = rr_ptr;
      scan_idx    = rr_ptr;
      pop_in      = '0;
      if (!stall) begin
         for (int k = 3; k >= 0; k--) begin
            scan_idx = rr_ptr + 2'(k);
            if (!fifo_in_empty[scan_idx]) begin
               grant_valid = 1'b1;
               grant_idx   = scan_idx;
            end
         end
      end
      if (grant_valid) begin
         pop_in[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      s1_word = fifo_in_data0;
      case (s1_src)
         2'd1:    s1_word = fifo_in_data1;
         2'd2:    s1_word = fifo_in_data2;
         2'd3:    s1_word = fifo_in_data3;
         default: s1_word = fifo_in_data0;
      endcase
      s1_dest = s1_word[FIFO_WORD_SIZE-1 -: 2];
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         rr_ptr   <= 2'd0;
         s1_valid <= 1'b0;
         s1_src   <= 2'd0;
         push_out <= '0;
         data_out <= '0;
         arb_idle <= 1'b1;
      end else begin
         if (grant_valid) begin
            rr_ptr <= grant_idx + 2'd1;
         end
         s1_valid <= grant_valid;
         s1_src   <= grant_idx;
         // A popped word is always delivered; almost-full only blocks new pops.
         if (s1_valid) begin
            data_out <= s1_word;
            push_out <= NUM_FIFOS'(1) << s1_dest;
         end else begin
            push_out <= '0;
         end
         arb_idle <= (&fifo_in_empty) & ~s1_valid & ~grant_valid;
      end
   end

endmodule

// File: tb/tb_arbitro_rr.sv
// tb/tb_arbitro_rr.sv - randomized and directed bench for arbitro_rr against a queue-based reference model
module tb_arbitro_rr;
   localparam int W = 10;

   logic         clk = 1'b0;
   logic         reset_L = 1'b1;
   logic         arb_en = 1'b0;
   logic [3:0]   fifo_in_empty = 4'hF;
   logic [3:0]   fifo_out_almost_full = 4'h0;
   logic [W-1:0] din [4];
   logic [3:0]   pop_in, push_out;
   logic [W-1:0] data_out;
   logic         arb_idle;

   always #5 clk = ~clk;

   arbitro_rr #(.NUM_FIFOS(4), .FIFO_WORD_SIZE(W)) dut (
      .clk(clk), .reset_L(reset_L), .arb_en(arb_en), .fifo_in_empty(fifo_in_empty),
      .fifo_in_data0(din[0]), .fifo_in_data1(din[1]), .fifo_in_data2(din[2]), .fifo_in_data3(din[3]),
      .fifo_out_almost_full(fifo_out_almost_full), .pop_in(pop_in), .push_out(push_out),
      .data_out(data_out), .arb_idle(arb_idle)
   );

   logic [W-1:0] mem [4][16];
   int           head [4];
   int           cnt [4];
   int           ptr_m, cyc;
   int           due_q[$];
   logic [W-1:0] word_q[$];
   logic [3:0]   exp_push;
   logic [W-1:0] exp_data;
   logic         exp_idle;
   bit           grant_prev;
   int           checks, errors;
   int           pop_log[$];
   int           push_log_p[$];
   int           push_log_d[$];

   task automatic chk(string name, int act, int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic load(int f, logic [W-1:0] w);
      if (cnt[f] < 16) begin
         mem[f][(head[f] + cnt[f]) % 16] = w;
         cnt[f]++;
      end
   endtask

   function automatic int model_grant();
      int i;
      if ((|fifo_out_almost_full) || !arb_en) return -1;
      for (int k = 0; k < 4; k++) begin
         i = (ptr_m + k) % 4;
         if (cnt[i] > 0) return i;
      end
      return -1;
   endfunction

   task automatic clear_logs();
      pop_log.delete();
      push_log_p.delete();
      push_log_d.delete();
   endtask

   task automatic cycle();
      int g;
      bit all_empty;
      logic [W-1:0] w;
      @(negedge clk);
      for (int i = 0; i < 4; i++) fifo_in_empty[i] = (cnt[i] == 0);
      #1;
      g = model_grant();
      all_empty = (cnt[0] == 0) && (cnt[1] == 0) && (cnt[2] == 0) && (cnt[3] == 0);
      chk("pop_in", int'(pop_in), (g >= 0) ? (1 << g) : 0);
      chk("push_out", int'(push_out), int'(exp_push));
      chk("data_out", int'(data_out), int'(exp_data));
      chk("arb_idle", int'(arb_idle), int'(exp_idle));
      chk("pop_of_empty", int'(pop_in & fifo_in_empty), 0);
      chk("push_onehot0", int'($countones(push_out) <= 1), 1);
      for (int i = 0; i < 4; i++) if (pop_in[i]) pop_log.push_back(i);
      if (push_out != 0) begin
         push_log_p.push_back(int'(push_out));
         push_log_d.push_back(int'(data_out));
      end
      @(posedge clk);
      #1;
      exp_idle   = all_empty && !grant_prev && (g < 0);
      grant_prev = (g >= 0);
      if (g >= 0) begin
         w = mem[g][head[g]];
         head[g] = (head[g] + 1) % 16;
         cnt[g]--;
         din[g] = w;
         due_q.push_back(cyc + 2);
         word_q.push_back(w);
         ptr_m = (g + 1) % 4;
         fifo_in_empty[g] = (cnt[g] == 0);
      end
      cyc++;
      if (due_q.size() > 0 && due_q[0] == cyc) begin
         w = word_q[0];
         exp_push = 4'b0001 << w[W-1 -: 2];
         exp_data = w;
         void'(due_q.pop_front());
         void'(word_q.pop_front());
      end else begin
         exp_push = 4'h0;
      end
   endtask

   task automatic run(int n);
      for (int k = 0; k < n; k++) cycle();
   endtask

   task automatic do_reset();
      #2;
      reset_L = 1'b0;
      #1;
      chk("rst_pop_in", int'(pop_in), 0);
      chk("rst_push_out", int'(push_out), 0);
      chk("rst_data_out", int'(data_out), 0);
      chk("rst_arb_idle", int'(arb_idle), 1);
      due_q.delete();
      word_q.delete();
      ptr_m = 0; exp_push = 4'h0; exp_data = '0; exp_idle = 1'b1; grant_prev = 1'b0;
      for (int i = 0; i < 4; i++) begin head[i] = 0; cnt[i] = 0; end
      fifo_in_empty = 4'hF;
      repeat (2) @(posedge clk);
      #3;
      reset_L = 1'b1;
   endtask

   initial begin
      int e1p[4], e1d[4], e4[4], e6[8];
      checks = 0; errors = 0; cyc = 0;
      for (int i = 0; i < 4; i++) din[i] = '0;
      do_reset();
      arb_en = 1'b1;
      run(2);

      // Directed 1: all four FIFOs loaded in the same cycle.
      clear_logs();
      load(0, 10'h0A6); load(1, 10'h145); load(2, 10'h278); load(3, 10'h389);
      run(8);
      e1p = '{1, 2, 4, 8}; e1d = '{'h0A6, 'h145, 'h278, 'h389};
      chk("t1_pop_count", pop_log.size(), 4);
      chk("t1_push_count", push_log_p.size(), 4);
      for (int k = 0; k < 4; k++) begin
         chk("t1_pop_order", pop_log[k], k);
         chk("t1_push_bits", push_log_p[k], e1p[k]);
         chk("t1_push_data", push_log_d[k], e1d[k]);
      end

      // Directed 2: two words in a single FIFO.
      clear_logs();
      load(0, 10'h15B); load(0, 10'h3CC);
      run(6);
      chk("t2_pop_count", pop_log.size(), 2);
      chk("t2_pop0", pop_log[0], 0);
      chk("t2_pop1", pop_log[1], 0);
      chk("t2_push0", push_log_p[0], 4'b0010);
      chk("t2_data0", push_log_d[0], 'h15B);
      chk("t2_push1", push_log_p[1], 4'b1000);
      chk("t2_data1", push_log_d[1], 'h3CC);
      chk("t2_idle", int'(arb_idle), 1);

      // Directed 3: almost-full raised right after a pop.
      clear_logs();
      load(0, 10'h201);
      cycle();
      load(1, 10'h0F0);
      fifo_out_almost_full = 4'b0001;
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("t3_pop_stalled", int'(pop_in), 0);
      end
      fifo_out_almost_full = 4'b0000;
      run(5);
      chk("t3_pop_count", pop_log.size(), 2);
      chk("t3_pop1", pop_log[1], 1);
      chk("t3_push0", push_log_p[0], 4'b0100);
      chk("t3_data0", push_log_d[0], 'h201);
      chk("t3_push1", push_log_p[1], 4'b0001);
      chk("t3_data1", push_log_d[1], 'h0F0);

      // Directed 4: arb_en low with every FIFO non-empty.
      clear_logs();
      arb_en = 1'b0;
      load(0, 10'h011); load(1, 10'h122); load(2, 10'h233); load(3, 10'h344);
      for (int k = 0; k < 3; k++) begin
         cycle();
         chk("t4_pop_blocked", int'(pop_in), 0);
         chk("t4_push_blocked", int'(push_out), 0);
      end
      arb_en = 1'b1;
      run(7);
      e4 = '{2, 3, 0, 1};
      chk("t4_pop_count", pop_log.size(), 4);
      for (int k = 0; k < 4; k++) chk("t4_pop_order", pop_log[k], e4[k]);

      // Directed 5: reset while a word sits in stage 1.
      load(2, 10'h24C);
      cycle();
      do_reset();
      clear_logs();
      load(1, 10'h111); load(3, 10'h3AB);
      run(6);
      chk("t5_pop_count", pop_log.size(), 2);
      chk("t5_pop0", pop_log[0], 1);
      chk("t5_pop1", pop_log[1], 3);
      chk("t5_push_count", push_log_p.size(), 2);
      chk("t5_data0", push_log_d[0], 'h111);
      chk("t5_data1", push_log_d[1], 'h3AB);

      // Directed 6: two continuously busy FIFOs starting from pointer 2.
      load(1, 10'h0AA);
      run(4);
      clear_logs();
      for (int k = 0; k < 4; k++) begin
         load(1, W'(10'h100 + k));
         load(3, W'(10'h300 + k));
      end
      run(11);
      e6 = '{3, 1, 3, 1, 3, 1, 3, 1};
      chk("t6_pop_count", pop_log.size(), 8);
      for (int k = 0; k < 8; k++) chk("t6_pop_order", pop_log[k], e6[k]);

      // Random traffic, stalls, enables and occasional resets.
      for (int n = 0; n < 600; n++) begin
         if ($urandom_range(0, 2) == 0) load($urandom_range(0, 3), W'($urandom));
         if ($urandom_range(0, 3) == 0) load($urandom_range(0, 3), W'($urandom));
         fifo_out_almost_full = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
         arb_en = ($urandom_range(0, 9) != 0);
         cycle();
         if ($urandom_range(0, 199) == 0) do_reset();
      end
      arb_en = 1'b1;
      fifo_out_almost_full = 4'h0;
      run(80);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/arbitro_rr.md
Name: arbitro_rr

Overview:
- Round-robin arbiter and router of the transaction layer.
- Sits between the four input FIFOs (FIFO_in0..3) and the four output FIFOs (FIFO_out0..3).
- Pops at most one word per cycle from a non-empty input FIFO, decodes the destination field in the word's two MSBs, and pushes the full word into the matching output FIFO.
- Stops issuing pops while any output FIFO reports almost-full, or while the FSM disables it.

Parameters:
- NUM_FIFOS, 4, number of input FIFOs and number of output FIFOs. The destination field is fixed at 2 bits, so this block supports 4 only.
- FIFO_WORD_SIZE, 10, word width. Bits [FIFO_WORD_SIZE-1:FIFO_WORD_SIZE-2] are the destination.

Ports:
- clk  in  1  system clock, rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- arb_en  in  1  from FSM; 1 allows new pops (ACTIVE/IDLE states), 0 blocks them (RESET/INIT).
- fifo_in_empty  in  4  empty flags of FIFO_in3..0, registered by the FIFOs.
- fifo_in_data0..3  in  FIFO_WORD_SIZE each  read data of FIFO_in0..3; valid the cycle after pop.
- fifo_out_almost_full  in  4  almost-full flags of FIFO_out3..0.
- pop_in  out  4  one-hot-or-zero pop strobes to FIFO_in3..0.
- push_out  out  4  one-hot-or-zero push strobes to FIFO_out3..0.
- data_out  out  FIFO_WORD_SIZE  word shared by all output FIFOs; qualified by push_out.
- arb_idle  out  1  1 when all inputs are empty and no word is in flight.

Behaviour:
- Reset (reset_L=0, async):
  - pop_in=0, push_out=0, data_out=0, arb_idle=1.
  - rr_ptr=0; stage-1 valid=0, src=0.
- Grant (cycle N, combinational from registered state and inputs):
  - stall = |fifo_out_almost_full OR !arb_en OR reset_L=0.
  - If !stall, search i = rr_ptr, rr_ptr+1, ... mod 4; the first i with fifo_in_empty[i]=0 gets pop_in[i]=1.
  - If no FIFO is non-empty, or stall is high, pop_in=0.
- Pointer: on a grant to i, rr_ptr <= (i+1) mod 4 at the end of cycle N. With no grant, rr_ptr holds.
- Stage 1 (cycle N+1):
  - s1_valid=1 and s1_src=i are registered at the end of cycle N.
  - The word is taken from fifo_in_data[s1_src] during N+1.
- Output (cycle N+2):
  - At the end of N+1, data_out <= word and push_out[word[9:8]] <= 1, other bits 0.
  - Latency from pop to push is 2 cycles.
  - Throughput is 1 word per cycle when not stalled.
- If no word is in stage 1: push_out <= 0 and data_out holds its last value.
- Almost-full stall:
  - Blocks new pops only.
  - A word already popped (in stage 1) is still pushed, even to a FIFO now flagged almost-full. The FSM threshold guarantees headroom of at least 2 words.
  - Pops resume in the first cycle in which all almost-full flags are 0.
- arb_en=0 mid-transfer: in-flight words complete; no new pops.
- Single non-empty FIFO with 1 word: popped once. Its empty flag is 1 in the following cycle, so no double pop.
- Several non-empty FIFOs: grants rotate starting from rr_ptr. No FIFO waits more than 3 grants.
- arb_idle = &fifo_in_empty AND !s1_valid AND pop_in==0, registered.
- Reset mid-operation: the in-flight word is discarded (no push). All state returns to reset values immediately.
- Invariants:
  - Never pop an empty FIFO.
  - Never push more than one output per cycle.
  - Never pop more than one input per cycle.

Test Plan:
1. Reset, then push 0x0A6, 0x145, 0x278, 0x389 into FIFO_in0..3 in the same cycle, arb_en=1.
   - pops in order in0, in1, in2, in3 on consecutive cycles.
   - push_out 0001, 0010, 0100, 1000 with data_out 0x0A6, 0x145, 0x278, 0x389, each 2 cycles after its pop.
2. FIFO_in0 holds 0x15B and 0x3CC; all other input FIFOs are empty.
   - back-to-back pops from in0 only.
   - push_out=0010 with data_out=0x15B, then push_out=1000 with data_out=0x3CC.
   - arb_idle=1 afterwards.
3. Raise fifo_out_almost_full[0] in the cycle after a pop of 0x201 from in0.
   - 0x201 is still pushed to FIFO_out2.
   - pop_in stays 0 while the flag is high.
   - Pops resume in the cycle the flag drops.
4. arb_en=0 with all input FIFOs non-empty.
   - pop_in=0, push_out=0.
   - Setting arb_en=1 produces the first pop from in[rr_ptr].
5. Assert reset_L=0 while stage 1 holds 0x24C.
   - No push occurs.
   - All outputs go to reset values asynchronously; rr_ptr=0 after release.
6. in1 and in3 are non-empty continuously and rr_ptr=2.
   - grants alternate in3, in1, in3, in1.
   - in0 and in2 are never popped.
